// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access path: FSM state encoding and
// default bus widths used by the MEM stage, this unit and dataMemory.
package mem_access_unit_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and the data memory: one request
// at a time, fixed read latency, registered response with range-error flag.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH   = mem_access_unit_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = mem_access_unit_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic                  busy
);

  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]  DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] LAT_INIT  = CNT_WIDTH'(READ_LATENCY - 1);

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    error_reg;
  logic [CNT_WIDTH-1:0]    count_reg;
  logic                    req_ready_reg;
  logic                    rsp_valid_reg;
  logic                    mem_we_reg;
  logic                    mem_re_reg;
  logic                    busy_reg;

  logic                    addr_bad;

  assign addr_bad = ({1'b0, req_addr} >= DEPTH_EXT);

  // Handshake and enable flags are registered alongside every state change so
  // they always equal the decode of state_reg.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      error_reg     <= 1'b0;
      count_reg     <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (addr_bad) begin
              error_reg     <= 1'b1;
              rdata_reg     <= '0;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else if (req_write) begin
              error_reg  <= 1'b0;
              rdata_reg  <= '0;
              mem_we_reg <= 1'b1;
              state_reg  <= WRITE;
            end else begin
              error_reg  <= 1'b0;
              count_reg  <= LAT_INIT;
              mem_re_reg <= 1'b1;
              state_reg  <= READ;
            end
          end
        end

        WRITE: begin
          mem_we_reg    <= 1'b0;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end

        READ: begin
          if (count_reg == '0) begin
            rdata_reg     <= mem_read_data;
            mem_re_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            count_reg <= count_reg - CNT_WIDTH'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          rsp_valid_reg <= 1'b0;
          mem_we_reg    <= 1'b0;
          mem_re_reg    <= 1'b0;
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_reg;
  assign rsp_valid        = rsp_valid_reg;
  assign rsp_rdata        = rdata_reg;
  assign rsp_error        = error_reg;
  assign mem_address      = addr_reg;
  assign mem_write_data   = wdata_reg;
  assign mem_write_enable = mem_we_reg;
  assign mem_read_enable  = mem_re_reg;
  assign busy             = busy_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: two units (READ_LATENCY 1 and 3), each with a memory model
// that only presents valid data after the enable has been held the full latency.
module tb_mem_access_unit;

  logic        clock;
  logic        reset            [2];
  logic        req_valid        [2];
  logic        req_ready        [2];
  logic        req_write        [2];
  logic [15:0] req_addr         [2];
  logic [15:0] req_wdata        [2];
  logic        rsp_valid        [2];
  logic        rsp_ready        [2];
  logic [15:0] rsp_rdata        [2];
  logic        rsp_error        [2];
  logic [15:0] mem_address      [2];
  logic [15:0] mem_write_data   [2];
  logic [15:0] mem_read_data    [2];
  logic        mem_write_enable [2];
  logic        mem_read_enable  [2];
  logic        busy             [2];
  logic        mem_load;

  int n_checks;
  int n_fail;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unit
    localparam int RL = (gi == 0) ? 1 : 3;
    logic [15:0] mem [256];
    int          re_run;

    mem_access_unit #(
      .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_DEPTH(256), .READ_LATENCY(RL)
    ) u_dut (
      .clock(clock), .reset(reset[gi]),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
      .req_write(req_write[gi]), .req_addr(req_addr[gi]), .req_wdata(req_wdata[gi]),
      .rsp_valid(rsp_valid[gi]), .rsp_ready(rsp_ready[gi]),
      .rsp_rdata(rsp_rdata[gi]), .rsp_error(rsp_error[gi]),
      .mem_address(mem_address[gi]), .mem_write_data(mem_write_data[gi]),
      .mem_read_data(mem_read_data[gi]),
      .mem_write_enable(mem_write_enable[gi]), .mem_read_enable(mem_read_enable[gi]),
      .busy(busy[gi])
    );

    always @(posedge clock) begin
      if (mem_load) begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'h5A00 + 16'(i);
      end else if (mem_write_enable[gi]) begin
        mem[mem_address[gi][7:0]] <= mem_write_data[gi];
      end
      re_run <= mem_read_enable[gi] ? re_run + 1 : 0;
    end

    // Data is valid only in the last cycle of a full-length read.
    assign mem_read_data[gi] = (mem_read_enable[gi] && re_run == RL - 1)
                               ? mem[mem_address[gi][7:0]] : 16'hDEAD;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request with rsp_ready high and measure latency/enables.
  task automatic run_req(input int u, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int exp_lat, input logic exp_err,
                         input logic [15:0] exp_rdata, input int exp_we, input int exp_re,
                         input string tag);
    int   c;
    int   we_n;
    int   re_n;
    logic addr_ok;
    we_n = 0;
    re_n = 0;
    addr_ok = 1'b1;
    check({tag, "_req_ready"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_write[u] = wr;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    rsp_ready[u] = 1'b1;
    tick();
    req_valid[u] = 1'b0;
    c = 1;
    while (!rsp_valid[u] && c <= 20) begin
      if (mem_write_enable[u]) begin
        we_n++;
        if (mem_address[u] !== addr || mem_write_data[u] !== wdata) addr_ok = 1'b0;
      end
      if (mem_read_enable[u]) begin
        re_n++;
        if (mem_address[u] !== addr) addr_ok = 1'b0;
      end
      tick();
      c++;
    end
    check({tag, "_latency"}, 32'(c), 32'(exp_lat));
    check({tag, "_rsp_error"}, 32'(rsp_error[u]), 32'(exp_err));
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata[u]), 32'(exp_rdata));
    check({tag, "_we_cycles"}, 32'(we_n), 32'(exp_we));
    check({tag, "_re_cycles"}, 32'(re_n), 32'(exp_re));
    check({tag, "_bus_values"}, 32'(addr_ok), 32'd1);
    check({tag, "_busy_resp"}, {30'd0, busy[u], req_ready[u]}, 32'b10);
    tick();
    check({tag, "_back_idle"}, {29'd0, rsp_valid[u], req_ready[u], busy[u]}, 32'b010);
    check({tag, "_addr_hold"}, 32'(mem_address[u]), 32'(addr));
  endtask

  initial begin
    int   c;
    int   hits;
    logic ok;
    n_checks = 0;
    n_fail   = 0;
    mem_load = 1'b1;
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1;
      req_valid[u] = 1'b0;
      req_write[u] = 1'b0;
      req_addr[u] = '0;
      req_wdata[u] = '0;
      rsp_ready[u] = 1'b1;
    end

    // 1: reset held two cycles
    tick();
    tick();
    mem_load = 1'b0;
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b0;
      check("reset_ctrl", {27'd0, req_ready[u], busy[u], rsp_valid[u], rsp_error[u],
                           mem_write_enable[u]}, 32'b10000);
      check("reset_re", 32'(mem_read_enable[u]), 32'd0);
      check("reset_rdata", 32'(rsp_rdata[u]), 32'd0);
      check("reset_bus", {mem_address[u], mem_write_data[u]}, 32'd0);
    end
    tick();

    // 2: store addr 1 = 16
    run_req(0, 1'b1, 16'd1, 16'd16, 2, 1'b0, 16'd0, 1, 0, "store_rl1");
    run_req(1, 1'b1, 16'd1, 16'd16, 2, 1'b0, 16'd0, 1, 0, "store_rl3");

    // 3: load back with both latencies
    run_req(0, 1'b0, 16'd1, 16'd0, 2, 1'b0, 16'd16, 0, 1, "load_rl1");
    run_req(1, 1'b0, 16'd1, 16'd0, 4, 1'b0, 16'd16, 0, 3, "load_rl3");

    // 4: range boundary
    run_req(0, 1'b0, 16'd256, 16'd0, 1, 1'b1, 16'd0, 0, 0, "load_256");
    run_req(0, 1'b0, 16'd255, 16'd0, 2, 1'b0, 16'h5AFF, 0, 1, "load_255");
    run_req(0, 1'b1, 16'hFFFF, 16'hBEEF, 1, 1'b1, 16'd0, 0, 0, "store_ffff");
    run_req(1, 1'b0, 16'd300, 16'd0, 1, 1'b1, 16'd0, 0, 0, "load_300_rl3");
    run_req(1, 1'b0, 16'd255, 16'd0, 4, 1'b0, 16'h5AFF, 0, 3, "load_255_rl3");

    // 5: response stalled while a second request pulses
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 16'd7;
    rsp_ready[0] = 1'b0;
    tick();
    req_write[0] = 1'b1;
    req_addr[0]  = 16'd9;
    req_wdata[0] = 16'h1234;
    c = 1;
    while (!rsp_valid[0] && c <= 10) begin
      req_valid[0] = ~req_valid[0];
      tick();
      c++;
    end
    check("stall_latency", 32'(c), 32'd2);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(rsp_valid[0] === 1'b1 && rsp_rdata[0] === 16'h5A07 && rsp_error[0] === 1'b0 &&
            req_ready[0] === 1'b0 && mem_write_enable[0] === 1'b0 &&
            mem_address[0] === 16'd7)) ok = 1'b0;
      req_valid[0] = ~req_valid[0];
      tick();
    end
    check("stall_stable", 32'(ok), 32'd1);
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    check("stall_still_resp", {30'd0, rsp_valid[0], req_ready[0]}, 32'b10);
    tick();
    check("stall_idle", {30'd0, req_ready[0], rsp_valid[0]}, 32'b10);
    check("stall_not_taken", 32'(mem_address[0]), 32'd7);
    tick();
    req_valid[0] = 1'b0;
    check("second_write", {15'd0, mem_write_enable[0], mem_address[0]}, {15'd0, 1'b1, 16'd9});
    check("second_wdata", 32'(mem_write_data[0]), 32'h1234);
    tick();
    check("second_resp", {30'd0, rsp_valid[0], rsp_error[0]}, 32'b10);
    tick();
    run_req(0, 1'b0, 16'd9, 16'd0, 2, 1'b0, 16'h1234, 0, 1, "load_9");

    // 6: reset in the second READ cycle (latency 3)
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = 16'd1;
    rsp_ready[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    check("abort_re_c1", 32'(mem_read_enable[1]), 32'd1);
    tick();
    check("abort_re_c2", 32'(mem_read_enable[1]), 32'd1);
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    check("abort_state", {28'd0, mem_read_enable[1], req_ready[1], busy[1], rsp_valid[1]},
          32'b0100);
    check("abort_addr", 32'(mem_address[1]), 32'd0);
    hits = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid[1] !== 1'b0) hits++;
      tick();
    end
    check("abort_no_rsp", 32'(hits), 32'd0);

    // reset and request together: request dropped
    reset[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_addr[1] = 16'd3;
    tick();
    reset[1] = 1'b0;
    req_valid[1] = 1'b0;
    tick();
    check("reset_wins", {29'd0, busy[1], mem_read_enable[1], req_ready[1]}, 32'b001);
    check("reset_wins_addr", 32'(mem_address[1]), 32'd0);
    run_req(1, 1'b0, 16'd1, 16'd0, 4, 1'b0, 16'd16, 0, 3, "recover_rl3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
